// File: rtl/smi_flit_reduce_stage_x2_pkg.sv
// Shared SMI definitions: eofc encoding and the per-half eofc rewrite helper.
package smi_flit_reduce_stage_x2_pkg;

    localparam int EOFC_W = 8;
    localparam logic [EOFC_W-1:0] EOFC_NOT_FINAL = '0;

    // Result of splitting one wide-flit eofc into its two narrow halves.
    typedef struct packed {
        logic [EOFC_W-1:0] lo;       // eofc carried by the low half
        logic [EOFC_W-1:0] hi;       // eofc carried by the high half
        logic              lo_last;  // frame ends inside the low half, high half is dropped
    } eofc_split_t;

    // Split an eofc for a flit of 2*half_w bytes into low/high half values.
    // Out-of-range counts saturate to a full final flit.
    function automatic eofc_split_t eofc_split(input logic [EOFC_W-1:0] eofc,
                                               input logic [EOFC_W-1:0] half_w);
        logic [EOFC_W:0] full_w;
        logic [EOFC_W:0] e;
        eofc_split_t     r;
        full_w    = {half_w, 1'b0};
        e         = ({1'b0, eofc} > full_w) ? full_w : {1'b0, eofc};
        r.lo      = EOFC_NOT_FINAL;
        r.hi      = EOFC_NOT_FINAL;
        r.lo_last = 1'b0;
        if (e == '0) begin
            r.lo_last = 1'b0;
        end else if (e <= {1'b0, half_w}) begin
            r.lo      = e[EOFC_W-1:0];
            r.lo_last = 1'b1;
        end else begin
            r.hi      = EOFC_W'(e - {1'b0, half_w});
        end
        return r;
    endfunction

endpackage

// File: rtl/smi_flit_reduce_stage_x2_half_select.sv
// Combinational half mux: picks the low or high half of a wide flit and
// rewrites its eofc for the narrow link.
module smi_flit_half_select
    import smi_flit_reduce_stage_x2_pkg::*;
#(
    parameter int FlitWidth = 4
) (
    input  logic [FlitWidth*16-1:0] in_data,
    input  logic [EOFC_W-1:0]       in_eofc,
    input  logic                    sel,
    output logic [FlitWidth*8-1:0]  out_data,
    output logic [EOFC_W-1:0]       out_eofc,
    output logic                    last_half
);

    localparam int HW = FlitWidth * 8;

    eofc_split_t split;

    // Select the half and its eofc; flag whether this half closes the entry.
    always_comb begin
        split     = eofc_split(in_eofc, EOFC_W'(FlitWidth));
        out_data  = sel ? in_data[2*HW-1:HW] : in_data[HW-1:0];
        out_eofc  = sel ? split.hi : split.lo;
        last_half = sel | split.lo_last;
    end

endmodule

// File: rtl/smi_flit_reduce_stage_x2.sv
// SMI flit width reduction stage: each wide flit is emitted as one or two
// narrow flits, low half first. A 2-entry ping-pong buffer keeps the output
// at one flit per cycle, and every output is driven from registers only.
module smi_flit_reduce_stage_x2
    import smi_flit_reduce_stage_x2_pkg::*;
#(
    parameter int FlitWidth = 4
) (
    input  logic                    clk,
    input  logic                    srst,
    input  logic                    smiInReady,
    input  logic [EOFC_W-1:0]       smiInEofc,
    input  logic [FlitWidth*16-1:0] smiInData,
    output logic                    smiInStop,
    output logic                    smiOutReady,
    output logic [EOFC_W-1:0]       smiOutEofc,
    output logic [FlitWidth*8-1:0]  smiOutData,
    input  logic                    smiOutStop
);

    localparam int DW = FlitWidth * 16;

    logic [1:0][DW-1:0]     h_data_q, h_data_d;
    logic [1:0][EOFC_W-1:0] h_eofc_q, h_eofc_d;
    logic                   wr_q, wr_d;
    logic                   rd_q, rd_d;
    logic                   sel_q, sel_d;
    logic [1:0]             cnt_q, cnt_d;

    logic in_acc;
    logic out_acc;
    logic last_half;
    logic free_entry;

    // The output view is always the currently selected half of the read entry.
    smi_flit_half_select #(.FlitWidth(FlitWidth)) u_half_select (
        .in_data   (h_data_q[rd_q]),
        .in_eofc   (h_eofc_q[rd_q]),
        .sel       (sel_q),
        .out_data  (smiOutData),
        .out_eofc  (smiOutEofc),
        .last_half (last_half)
    );

    assign smiInStop   = (cnt_q == 2'd2);
    assign smiOutReady = (cnt_q != 2'd0);

    assign in_acc     = smiInReady & ~smiInStop;
    assign out_acc    = smiOutReady & ~smiOutStop;
    assign free_entry = out_acc & last_half;

    // Next-state for buffer, pointers, half select and occupancy.
    always_comb begin
        h_data_d = h_data_q;
        h_eofc_d = h_eofc_q;
        wr_d     = wr_q;
        rd_d     = rd_q;
        sel_d    = sel_q;
        if (in_acc) begin
            h_data_d[wr_q] = smiInData;
            h_eofc_d[wr_q] = smiInEofc;
            wr_d           = ~wr_q;
        end
        if (out_acc) begin
            if (last_half) begin
                sel_d = 1'b0;
                rd_d  = ~rd_q;
            end else begin
                sel_d = 1'b1;
            end
        end
        cnt_d = cnt_q + {1'b0, in_acc} - {1'b0, free_entry};
    end

    // State registers; reset discards both entries and restarts at a low half.
    always_ff @(posedge clk) begin
        if (srst) begin
            h_data_q <= '0;
            h_eofc_q <= '0;
            wr_q     <= 1'b0;
            rd_q     <= 1'b0;
            sel_q    <= 1'b0;
            cnt_q    <= 2'd0;
        end else begin
            h_data_q <= h_data_d;
            h_eofc_q <= h_eofc_d;
            wr_q     <= wr_d;
            rd_q     <= rd_d;
            sel_q    <= sel_d;
            cnt_q    <= cnt_d;
        end
    end

endmodule

// File: tb/tb_smi_flit_reduce_stage_x2.sv
// Directed bench for smi_flit_reduce_stage_x2 with FlitWidth=4.
module tb_smi_flit_reduce_stage_x2;

    logic        clk = 1'b0;
    logic        srst;
    logic        smiInReady;
    logic [7:0]  smiInEofc;
    logic [63:0] smiInData;
    logic        smiInStop;
    logic        smiOutReady;
    logic [7:0]  smiOutEofc;
    logic [31:0] smiOutData;
    logic        smiOutStop;

    int n_cmp = 0;
    int n_err = 0;

    smi_flit_reduce_stage_x2 #(.FlitWidth(4)) dut (
        .clk         (clk),
        .srst        (srst),
        .smiInReady  (smiInReady),
        .smiInEofc   (smiInEofc),
        .smiInData   (smiInData),
        .smiInStop   (smiInStop),
        .smiOutReady (smiOutReady),
        .smiOutEofc  (smiOutEofc),
        .smiOutData  (smiOutData),
        .smiOutStop  (smiOutStop)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one clock; inputs are driven and outputs sampled 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_out(input string tag, input logic [31:0] d, input logic [7:0] e);
        chk({tag, ".rdy"}, 64'(smiOutReady), 64'd1);
        chk({tag, ".data"}, 64'(smiOutData), 64'(d));
        chk({tag, ".eofc"}, 64'(smiOutEofc), 64'(e));
    endtask

    task automatic send_one(input logic [63:0] d, input logic [7:0] e);
        smiInReady = 1'b1;
        smiInData  = d;
        smiInEofc  = e;
        step();
        smiInReady = 1'b0;
        smiInData  = '0;
        smiInEofc  = '0;
    endtask

    logic [31:0] exp_q[$];
    int          outs;
    int          sent;
    int          gaps;
    int          first_out;
    int          last_out;

    initial begin
        srst       = 1'b1;
        smiInReady = 1'b0;
        smiInEofc  = '0;
        smiInData  = '0;
        smiOutStop = 1'b0;

        // 1. reset
        step();
        step();
        srst = 1'b0;
        step();
        chk("rst.rdy",  64'(smiOutReady), 64'd0);
        chk("rst.stop", 64'(smiInStop),   64'd0);
        chk("rst.eofc", 64'(smiOutEofc),  64'd0);
        chk("rst.data", 64'(smiOutData),  64'd0);

        // 2. full non-final flit -> two halves
        send_one(64'h8877665544332211, 8'd0);
        chk_out("full.lo", 32'h44332211, 8'd0);
        step();
        chk_out("full.hi", 32'h88776655, 8'd0);
        step();
        chk("full.idle", 64'(smiOutReady), 64'd0);

        // 3. short final flit -> low half only
        send_one(64'h0000000000CCBBAA, 8'd3);
        chk_out("short.lo", 32'h00CCBBAA, 8'd3);
        step();
        chk("short.idle", 64'(smiOutReady), 64'd0);

        // 4. split final flit -> eofc rewritten on the high half
        send_one(64'h0000665544332211, 8'd6);
        chk_out("split.lo", 32'h44332211, 8'd0);
        step();
        chk_out("split.hi", 32'h00006655, 8'd2);
        step();
        chk("split.idle", 64'(smiOutReady), 64'd0);

        // 5. streaming: 8 wide flits offered continuously
        exp_q.delete();
        for (int i = 0; i < 8; i++) begin
            exp_q.push_back(32'hA000_0000 + 32'(2*i));
            exp_q.push_back(32'hA000_0000 + 32'(2*i + 1));
        end
        outs      = 0;
        sent      = 0;
        gaps      = 0;
        first_out = -1;
        last_out  = -1;
        for (int cyc = 0; cyc < 60; cyc++) begin
            if (smiOutReady) begin
                if (first_out < 0) first_out = cyc;
                last_out = cyc;
                if (outs < 16) begin
                    chk($sformatf("strm.d%0d", outs), 64'(smiOutData), 64'(exp_q[outs]));
                    chk($sformatf("strm.e%0d", outs), 64'(smiOutEofc), 64'd0);
                end
                outs++;
            end else if (first_out >= 0 && outs < 16) begin
                gaps++;
            end
            if (sent < 8) begin
                smiInReady = 1'b1;
                smiInEofc  = 8'd0;
                smiInData  = {32'hA000_0000 + 32'(2*sent + 1), 32'hA000_0000 + 32'(2*sent)};
                if (!smiInStop) sent++;
            end else begin
                smiInReady = 1'b0;
                smiInData  = '0;
            end
            step();
        end
        smiInReady = 1'b0;
        chk("strm.count", 64'(outs), 64'd16);
        chk("strm.gaps",  64'(gaps), 64'd0);
        chk("strm.span",  64'(last_out - first_out), 64'd15);
        chk("strm.sent",  64'(sent), 64'd8);

        // 6. stall on a high half with both entries full
        send_one(64'h1111_1111_0000_0000, 8'd0);   // P
        chk_out("stl.plo", 32'h0000_0000, 8'd0);
        send_one(64'h3333_3333_2222_2222, 8'd0);   // Q
        chk_out("stl.phi0", 32'h1111_1111, 8'd0);
        chk("stl.full", 64'(smiInStop), 64'd1);
        smiOutStop = 1'b1;
        smiInReady = 1'b1;
        smiInEofc  = 8'd0;
        smiInData  = 64'h5555_5555_4444_4444;      // R, must wait
        for (int i = 0; i < 5; i++) begin
            step();
            chk($sformatf("stl.hold%0d.d", i), 64'(smiOutData), 64'h1111_1111);
            chk($sformatf("stl.hold%0d.e", i), 64'(smiOutEofc), 64'd0);
            chk($sformatf("stl.hold%0d.s", i), 64'(smiInStop),  64'd1);
        end
        smiOutStop = 1'b0;
        step();
        chk_out("stl.qlo", 32'h2222_2222, 8'd0);
        step();
        smiInReady = 1'b0;
        chk_out("stl.qhi", 32'h3333_3333, 8'd0);

        // reset mid-frame: R's low half is pending, discard everything
        srst = 1'b1;
        step();
        srst = 1'b0;
        chk("srst.rdy",  64'(smiOutReady), 64'd0);
        chk("srst.stop", 64'(smiInStop),   64'd0);
        chk("srst.data", 64'(smiOutData),  64'd0);
        chk("srst.eofc", 64'(smiOutEofc),  64'd0);
        send_one(64'h7777_7777_6666_6666, 8'd0);
        chk_out("post.lo", 32'h6666_6666, 8'd0);
        step();
        chk_out("post.hi", 32'h7777_7777, 8'd0);
        step();
        chk("post.idle", 64'(smiOutReady), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
